// File: rtl/pool_pkg.sv
// Shared constants for the pooled-map output path: pixel width, map geometry
// and the layout of a tagged buffer entry {eol, eof, data}.
package pool_pkg;

    localparam int POOL_DATA_W = 32;
    localparam int POOL_OUT_W  = 149;
    localparam int POOL_OUT_H  = 149;

    localparam int ENTRY_W = POOL_DATA_W + 2;
    localparam int EOL_BIT = POOL_DATA_W + 1;
    localparam int EOF_BIT = POOL_DATA_W;

    // Entry geometry for a non-default pixel width.
    function automatic int entry_w(input int dw);
        return dw + 2;
    endfunction

    function automatic int eol_pos(input int dw);
        return dw + 1;
    endfunction

    function automatic int eof_pos(input int dw);
        return dw;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO with occupancy count and flush.
// The head word reads as zero while the FIFO is empty.
module sync_fifo_fwft #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 16,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             pop_eff;
    logic             push_eff;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign pop_eff  = pop && !empty;
    // A push into a full FIFO is accepted only when the head leaves this cycle.
    assign push_eff = push && (!full || pop_eff);
    assign rdata    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_eff) wr_ptr <= wr_ptr + 1'b1;
            if (pop_eff)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_eff, pop_eff})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_eff && !flush) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/pool_stream_buffer.sv
// Tags pooled pixels with end-of-row/end-of-frame, buffers them in a FWFT
// FIFO and presents them on valid/ready; drops and flags pixels when full.
module pool_stream_buffer
    import pool_pkg::*;
#(
    parameter int DATA_WIDHT = POOL_DATA_W,
    parameter int OUT_WIDHT  = POOL_OUT_W,
    parameter int OUT_HEIGHT = POOL_OUT_H,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            Soft_Clr,
    input  logic [DATA_WIDHT-1:0]           Data_In,
    input  logic                            Valid_In,
    output logic [DATA_WIDHT-1:0]           Data_Out,
    output logic                            Valid_Out,
    input  logic                            Ready_In,
    output logic                            Last_Col,
    output logic                            Last_Frame,
    output logic                            Frame_Done,
    output logic                            Overflow,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] Fill_Level
);

    localparam int EW = entry_w(DATA_WIDHT);
    localparam int XW = (OUT_WIDHT > 1) ? $clog2(OUT_WIDHT) : 1;
    localparam int YW = (OUT_HEIGHT > 1) ? $clog2(OUT_HEIGHT) : 1;
    localparam logic [XW-1:0] COL_LAST = XW'(OUT_WIDHT - 1);
    localparam logic [YW-1:0] ROW_LAST = YW'(OUT_HEIGHT - 1);

    logic [XW-1:0] col;
    logic [YW-1:0] row;
    logic          eol;
    logic          eof;
    logic [EW-1:0] entry_in;
    logic [EW-1:0] entry_head;
    logic          fifo_full;
    logic          fifo_empty;
    logic          pop_eff;
    logic          drop;

    assign eol      = (col == COL_LAST);
    assign eof      = eol && (row == ROW_LAST);
    assign entry_in = {eol, eof, Data_In};

    assign Valid_Out  = !fifo_empty;
    assign pop_eff    = Valid_Out && Ready_In;
    assign drop       = Valid_In && fifo_full && !pop_eff && !Soft_Clr;
    assign Data_Out   = entry_head[DATA_WIDHT-1:0];
    assign Last_Col   = entry_head[eol_pos(DATA_WIDHT)];
    assign Last_Frame = entry_head[eof_pos(DATA_WIDHT)];

    sync_fifo_fwft #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst),
        .flush (Soft_Clr),
        .push  (Valid_In),
        .pop   (Ready_In),
        .wdata (entry_in),
        .rdata (entry_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (Fill_Level)
    );

    // Geometry follows every source pixel, dropped or not, to stay frame-aligned.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col <= '0;
            row <= '0;
        end else if (Soft_Clr) begin
            col <= '0;
            row <= '0;
        end else if (Valid_In) begin
            if (eol) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            Overflow   <= 1'b0;
            Frame_Done <= 1'b0;
        end else if (Soft_Clr) begin
            Overflow   <= 1'b0;
            Frame_Done <= 1'b0;
        end else begin
            if (drop) Overflow <= 1'b1;
            Frame_Done <= pop_eff && Last_Frame;
        end
    end

endmodule
